// File: rtl/trackball_pkg.sv
// Shared definitions for the trackball controller: quadrature step encoding,
// the {prev,cur} decode function and saturation-limit helpers.
package trackball_pkg;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_UP      = 2'd1,
    STEP_DOWN    = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_t;

  // Forward Gray order on {A,B} is 00 -> 01 -> 11 -> 10 -> 00.
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t st;
    case ({prev, cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: st = STEP_UP;
      4'b0100, 4'b1101, 4'b1011, 4'b0010: st = STEP_DOWN;
      4'b0000, 4'b0101, 4'b1111, 4'b1010: st = STEP_NONE;
      default:                            st = STEP_ILLEGAL;
    endcase
    return st;
  endfunction

  function automatic int sat_hi(input int w);
    return (1 <<< (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 <<< (w - 1));
  endfunction

  function automatic int sel_width(input int players);
    return (players > 1) ? $clog2(players) : 1;
  endfunction

endpackage

// File: rtl/trackball_ctrl_if.sv
// Pin/CPU-side bundle of the trackball controller: quadrature inputs,
// latch strobe, player select and the registered read outputs.
interface trackball_ctrl_if
  import trackball_pkg::*;
#(
  parameter int PLAYERS = 2,
  parameter int CNT_W   = 8
);
  localparam int SEL_W = sel_width(PLAYERS);

  logic [2*PLAYERS-1:0] quad_a;
  logic [2*PLAYERS-1:0] quad_b;
  logic                 latch;
  logic [SEL_W-1:0]     player_sel;
  logic [CNT_W-1:0]     pos_x;
  logic [CNT_W-1:0]     pos_y;
  logic                 ovf;

  modport master (output quad_a, quad_b, latch, player_sel, input pos_x, pos_y, ovf);
  modport slave  (input quad_a, quad_b, latch, player_sel, output pos_x, pos_y, ovf);
endinterface

// File: rtl/trackball_ctrl_quad_axis.sv
// Single quadrature axis: synchroniser, optional stability filter
// (TRACKBALL_FILTER_EN), step decode, position counter and error flag.
module quad_axis
  import trackball_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int DELTA  = 1,
  parameter int FILT_W = 3
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             a,
  input  logic             b,
  input  logic             latch,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);
  localparam logic signed [CNT_W-1:0] SAT_HI = CNT_W'(sat_hi(CNT_W));
  localparam logic signed [CNT_W-1:0] SAT_LO = CNT_W'(sat_lo(CNT_W));

  logic [1:0]       ab_p0, ab_p1, ab_p2, ab_prev;
  logic [CNT_W-1:0] cnt_q, cnt_base, cnt_nxt;
  logic             err_q, sat;
  step_t            step;

  // Returns {saturated, next}; relative counters clamp, absolute ones wrap.
  function automatic logic [CNT_W:0] step_count(input logic [CNT_W-1:0] base, input step_t st);
    logic signed [CNT_W-1:0] base_s;
    logic [CNT_W-1:0]        nxt;
    logic                    hit;
    base_s = $signed(base);
    nxt    = base;
    hit    = 1'b0;
    if (st == STEP_UP) begin
      if (DELTA != 0 && base_s == SAT_HI) hit = 1'b1;
      else nxt = base + CNT_W'(1);
    end else if (st == STEP_DOWN) begin
      if (DELTA != 0 && base_s == SAT_LO) hit = 1'b1;
      else nxt = base - CNT_W'(1);
    end
    return {hit, nxt};
  endfunction

  // Stage p0/p1: two-flop synchroniser on the asynchronous pins
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ab_p0 <= 2'b00;
      ab_p1 <= 2'b00;
    end else begin
      ab_p0 <= {a, b};
      ab_p1 <= ab_p0;
    end
  end

`ifdef TRACKBALL_FILTER_EN
  // Stage p2: each bit follows its input only after FILT_W identical samples
  localparam int RUN_W = $clog2(FILT_W + 1);
  logic [RUN_W-1:0] run_q [2];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ab_p2 <= 2'b00;
      for (int i = 0; i < 2; i++) run_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ab_p1[i] == ab_p2[i]) begin
          run_q[i] <= '0;
        end else if (run_q[i] == RUN_W'(FILT_W - 1)) begin
          ab_p2[i] <= ab_p1[i];
          run_q[i] <= '0;
        end else begin
          run_q[i] <= run_q[i] + RUN_W'(1);
        end
      end
    end
  end
`else
  assign ab_p2 = ab_p1;
`endif

  // A latch restarts a relative counter from zero so a coincident step is kept.
  always_comb begin
    step                = decode_step(ab_prev, ab_p2);
    cnt_base            = (latch && DELTA != 0) ? '0 : cnt_q;
    {sat, cnt_nxt}      = step_count(cnt_base, step);
  end

  // Stage p3: decode/update of previous state, counter and sticky error
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ab_prev <= 2'b00;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      ab_prev <= ab_p2;
      cnt_q   <= cnt_nxt;
      err_q   <= (latch ? 1'b0 : err_q) | sat | (step == STEP_ILLEGAL);
    end
  end

  assign cnt = cnt_q;
  assign err = err_q;
endmodule

// File: rtl/trackball_ctrl.sv
// Multi-player trackball counter bank with frame-latched hold registers and a
// registered player-select read mux. Optional input filter: TRACKBALL_FILTER_EN.
module trackball_ctrl
  import trackball_pkg::*;
#(
  parameter int PLAYERS = 2,
  parameter int CNT_W   = 8,
  parameter int DELTA   = 1,
  parameter int FILT_W  = 3
) (
  input  logic             clk,
  input  logic             clr_n,
  trackball_ctrl_if.slave  bus
);
  localparam int AXES = 2 * PLAYERS;

  logic [CNT_W-1:0] cnt [AXES];
  logic [AXES-1:0]  err;
  logic [CNT_W-1:0] hold_x [PLAYERS];
  logic [CNT_W-1:0] hold_y [PLAYERS];
  logic [PLAYERS-1:0] ovf_hold;
  logic [CNT_W-1:0] pos_x_q, pos_y_q;
  logic             ovf_q;
  int               sel_idx;

  // Axis 2p is player p X, axis 2p+1 is player p Y.
  for (genvar ax = 0; ax < AXES; ax++) begin : g_axis
    quad_axis #(
      .CNT_W (CNT_W),
      .DELTA (DELTA),
      .FILT_W(FILT_W)
    ) u_axis (
      .clk  (clk),
      .clr_n(clr_n),
      .a    (bus.quad_a[ax]),
      .b    (bus.quad_b[ax]),
      .latch(bus.latch),
      .cnt  (cnt[ax]),
      .err  (err[ax])
    );
  end

  // Stage hold: frame snapshot of every counter and per-player error
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int p = 0; p < PLAYERS; p++) begin
        hold_x[p] <= '0;
        hold_y[p] <= '0;
      end
      ovf_hold <= '0;
    end else if (bus.latch) begin
      for (int p = 0; p < PLAYERS; p++) begin
        hold_x[p]   <= cnt[2*p];
        hold_y[p]   <= cnt[2*p+1];
        ovf_hold[p] <= err[2*p] | err[2*p+1];
      end
    end
  end

  always_comb begin
    sel_idx = (int'(bus.player_sel) < PLAYERS) ? int'(bus.player_sel) : 0;
  end

  // Stage out: registered read mux
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pos_x_q <= '0;
      pos_y_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pos_x_q <= hold_x[sel_idx];
      pos_y_q <= hold_y[sel_idx];
      ovf_q   <= ovf_hold[sel_idx];
    end
  end

  assign bus.pos_x = pos_x_q;
  assign bus.pos_y = pos_y_q;
  assign bus.ovf   = ovf_q;
endmodule
